// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: command sequencer in front of an SR flip-flop stage.
// Queues set/clear requests, turns each into a clean s or r pulse (never
// both), then watches the q/qbar feedback to confirm the new state.
// Reports confirmations (done), rejected requests (drop) and sticky
// confirmation timeouts (err).
module sr_drive_ctrl #(
    parameter int PULSE_W = 2,  // cycles s or r is held high per command
    parameter int TIMEOUT = 8,  // cycles allowed after the pulse for feedback
    parameter int DEPTH   = 4   // command queue depth, power of two
) (
    input  logic clock,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    output logic req_ready,
    input  logic q,
    input  logic qbar,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err,
    output logic drop
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PCNT_W = $clog2(PULSE_W + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_CHECK
    } state_e;

    state_e              state_q, state_d;
    logic                fifo_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                target_q, target_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                s_q, s_d;
    logic                r_q, r_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;

    logic req_valid;
    logic req_both;
    logic full;
    logic push;
    logic pop;
    logic head;
    logic confirmed;

    // Request decode, queue pointer/count bookkeeping and drop detection.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        req_valid = set_req ^ clr_req;
        req_both  = set_req & clr_req;
        // Fullness uses the registered count: a pop on the same edge does
        // not make room for an incoming request.
        full      = (count_q == CNT_W'(DEPTH));
        push      = req_valid & ~full;
        pop       = (state_q == ST_IDLE) && (count_q != '0);
        head      = fifo_q[rd_ptr_q];

        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ready_d = (count_d < CNT_W'(DEPTH));
        drop_d  = req_both | (req_valid & full);
    end

    // Sequencer: pop a command, drive the pulse, then wait for feedback.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        pcnt_d   = pcnt_q;
        tcnt_d   = tcnt_q;
        s_d      = 1'b0;
        r_d      = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        // q == qbar is invalid feedback and never counts as confirmation.
        confirmed = (q == target_q) && (qbar == ~target_q);

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    target_d = head;
                    pcnt_d   = PCNT_W'(PULSE_W);
                    s_d      = head;
                    r_d      = ~head;
                    state_d  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                s_d    = s_q;
                r_d    = r_q;
                pcnt_d = pcnt_q - PCNT_W'(1);
                if (pcnt_q == PCNT_W'(1)) begin
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    tcnt_d  = TCNT_W'(TIMEOUT);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (confirmed) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tcnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Queue storage: written on accepted pushes only.
    always_ff @(posedge clock) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // count are, so stale entries are never read after a flush.
        if (push) begin
            fifo_q[wr_ptr_q] <= set_req;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values computed by the combinational blocks.
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            target_q <= 1'b0;
            pcnt_q   <= '0;
            tcnt_q   <= '0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            target_q <= target_d;
            pcnt_q   <= pcnt_d;
            tcnt_q   <= tcnt_d;
            s_q      <= s_d;
            r_q      <= r_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign s         = s_q;
    assign r         = r_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign drop      = drop_q;
    assign err       = err_q;
    assign req_ready = ready_q;

endmodule
